// File: rtl/addsub_pkg.sv
// Shared constants for the nibble-serial add/subtract sequencer.
package addsub_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

endpackage

// File: rtl/addsub_nibble.sv
// Combinational 4-bit add/subtract slice: {cout,sum} = a + (sub ? ~b : b) + cin.
module addsub_nibble
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic [NIBBLE_W-1:0] b_eff
);

  // Invert B for subtraction, then one 5-bit add including carry-in.
  always_comb begin
    b_eff       = sub ? ~b : b;
    {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{NIBBLE_W{1'b0}}, cin};
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-precision add/subtract: one nibble per clock, LSB first, through a
// single 4-bit slice with the carry chained in a register.
module nibble_serial_addsub
  import addsub_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = NIBBLE_W * NIBBLES,
  localparam int IDX_W   = $clog2(NIBBLES)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             control_in,
  input  logic             ack_in,
  output logic             ready_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow_out,
  output logic             zero_out
);

  logic [1:0]                        state;
  logic [IDX_W-1:0]                  idx;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]  a_q, b_q, sum_q, sum_nxt;
  logic                              sub_q;
  logic                              carry_q;

  logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib, b_eff;
  logic                cout;
  logic                last;
  logic                unused_b_eff_lo;

  assign a_nib = a_q[idx];
  assign b_nib = b_q[idx];
  assign last  = (idx == IDX_W'(NIBBLES - 1));

  addsub_nibble u_slice (
    .a     (a_nib),
    .b     (b_nib),
    .sub   (sub_q),
    .cin   (carry_q),
    .sum   (s_nib),
    .cout  (cout),
    .b_eff (b_eff)
  );

  // Only the sign bit of the effective operand feeds the overflow flag.
  assign unused_b_eff_lo = ^b_eff[NIBBLE_W-2:0];

  // Result with the current slice output merged in at nibble idx.
  always_comb begin
    sum_nxt      = sum_q;
    sum_nxt[idx] = s_nib;
  end

  // FSM, operand capture, nibble accumulation and final flag registration.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state        <= S_IDLE;
      idx          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      carry_q      <= 1'b0;
      sum_q        <= '0;
      carry_out    <= 1'b0;
      overflow_out <= 1'b0;
      zero_out     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_in) begin
            a_q     <= a_in;
            b_q     <= b_in;
            sub_q   <= control_in;
            carry_q <= control_in;
            idx     <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          sum_q   <= sum_nxt;
          carry_q <= cout;
          if (last) begin
            // Final nibble: a_nib/b_eff/s_nib carry the word's sign bits.
            state        <= S_DONE;
            carry_out    <= cout;
            overflow_out <= (a_nib[NIBBLE_W-1] == b_eff[NIBBLE_W-1]) &&
                            (s_nib[NIBBLE_W-1] != a_nib[NIBBLE_W-1]);
            zero_out     <= (sum_nxt == '0);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (ack_in) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready_out = (state == S_IDLE);
  assign valid_out = (state == S_DONE);
  assign sum_out   = sum_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed and randomised checks of the nibble-serial add/subtract sequencer.
module tb_nibble_serial_addsub;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         ctl;
  logic         ack;
  logic         ready, valid;
  logic [W-1:0] sum;
  logic         carry, ovf, zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .start_in     (start),
    .a_in         (a),
    .b_in         (b),
    .control_in   (ctl),
    .ack_in       (ack),
    .ready_out    (ready),
    .valid_out    (valid),
    .sum_out      (sum),
    .carry_out    (carry),
    .overflow_out (ovf),
    .zero_out     (zero)
  );

  // Issue one request and return the number of clocks until valid (-1 on timeout).
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL ready_wait: ready=%0b required 1", ready);
    end
    start = 1'b1; a = av; b = bv; ctl = cv;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL valid_timeout: no valid within 20 clocks");
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ready, valid, sum, carry, ovf, zero} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset: rdy=%0b vld=%0b sum=%h c=%0b o=%0b z=%0b required 1 0 0000 0 0 0",
               ready, valid, sum, carry, ovf, zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vec(input string name, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic cv,
                          input logic [W-1:0] es, input logic ec,
                          input logic eo, input logic ez);
    int lat;
    do_op(av, bv, cv, lat);
    checks++;
    if (lat !== NIBBLES) begin
      errors++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, NIBBLES);
    end
    checks++;
    if ({sum, carry, ovf, zero} !== {es, ec, eo, ez}) begin
      errors++;
      $display("FAIL %s: sum=%h c=%0b o=%0b z=%0b required sum=%h c=%0b o=%0b z=%0b",
               name, sum, carry, ovf, zero, es, ec, eo, ez);
    end
    do_ack();
  endtask

  task automatic test_arith();
    test_vec("add",       16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
    test_vec("sub_borrow",16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    test_vec("sub_ovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    test_vec("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    test_vec("add_zero",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    test_vec("sub_equal", 16'h5A5A, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
  endtask

  // start held during RUN and DONE must be ignored; outputs hold while ack is low.
  task automatic test_handshake();
    int lat;
    @(negedge clk);
    start = 1'b1; a = 16'h0102; b = 16'h0304; ctl = 1'b0;
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF; ctl = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (valid) begin lat = i; break; end
    end
    checks++;
    if (lat !== NIBBLES || sum !== 16'h0406) begin
      errors++;
      $display("FAIL hs_run_start: lat=%0d sum=%h required %0d 0406", lat, sum, NIBBLES);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({valid, ready, sum, carry, ovf, zero} !== {1'b1, 1'b0, 16'h0406, 3'b000}) begin
        errors++;
        $display("FAIL hs_hold: vld=%0b rdy=%0b sum=%h required 1 0 0406", valid, ready, sum);
      end
    end
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0; start = 1'b0;
    checks++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL hs_ack: rdy=%0b vld=%0b required 1 0", ready, valid);
    end
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1 || sum !== 16'h0406) begin
      errors++;
      $display("FAIL hs_start_with_ack: rdy=%0b sum=%h required 1 0406", ready, sum);
    end
  endtask

  // Ready one clock after ack, with the next request launched immediately.
  task automatic test_back_to_back();
    int lat;
    do_op(16'h1111, 16'h2222, 1'b0, lat);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: rdy=%0b required 1", ready);
    end
    start = 1'b1; a = 16'h3000; b = 16'h0456; ctl = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (valid) begin lat = i; break; end
    end
    checks++;
    if (lat !== NIBBLES || sum !== 16'h2BAA || carry !== 1'b1) begin
      errors++;
      $display("FAIL b2b_op: lat=%0d sum=%h c=%0b required %0d 2baa 1", lat, sum, carry, NIBBLES);
    end
    do_ack();
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1'b1; a = 16'h7777; b = 16'h1111; ctl = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ready, valid, sum, carry, ovf, zero} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      errors++;
      $display("FAIL mid_run_reset: rdy=%0b vld=%0b sum=%h c=%0b o=%0b z=%0b required 1 0 0000 0 0 0",
               ready, valid, sum, carry, ovf, zero);
    end
    rst_n = 1'b1;
    test_vec("after_reset", 16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int          lat;
    logic [W-1:0] av, bv, es;
    logic        cv, ec, eo, ez;
    logic [W:0]  wide;
    for (int n = 0; n < 1000; n++) begin
      av = W'($urandom);
      bv = W'($urandom);
      cv = 1'($urandom_range(0, 1));
      if (cv) begin
        es = av - bv;
        ec = (av >= bv);
        eo = (av[W-1] != bv[W-1]) && (es[W-1] != av[W-1]);
      end else begin
        wide = {1'b0, av} + {1'b0, bv};
        es = wide[W-1:0];
        ec = wide[W];
        eo = (av[W-1] == bv[W-1]) && (es[W-1] != av[W-1]);
      end
      ez = (es == '0);
      do_op(av, bv, cv, lat);
      checks++;
      if (lat !== NIBBLES) begin
        errors++;
        $display("FAIL rand_latency: op %0d got %0d required %0d", n, lat, NIBBLES);
      end
      checks++;
      if ({sum, carry, ovf, zero} !== {es, ec, eo, ez}) begin
        errors++;
        $display("FAIL rand_op: %h %s %h -> sum=%h c=%0b o=%0b z=%0b required %h %0b %0b %0b",
                 av, cv ? "-" : "+", bv, sum, carry, ovf, zero, es, ec, eo, ez);
      end
      do_ack();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ack = 1'b0;
    a = '0; b = '0; ctl = 1'b0;
    test_reset();
    test_arith();
    test_handshake();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
